// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receive framer (start check, LSB-first data, stop check).
// Optional parity bit and parity_error output when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_serial,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_error,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, nxt;
  logic [1:0] sync;
  logic [TW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic rx_s, mid, full, perr;
  assign rx_s = sync[1];
  assign mid  = sample_tick && cnt == TW'(OVERSAMPLE/2-1);
  assign full = sample_tick && cnt == TW'(OVERSAMPLE-1);
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = sample_tick && !rx_s ? START : IDLE;
      START:     nxt = mid ? (rx_s ? IDLE : DATA) : START;
      DATA:      nxt = full && bit_cnt == BW'(DATA_BITS-1) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:    nxt = full ? STOP : PARITY;
`endif
      STOP:      nxt = full ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: nxt = sample_tick && rx_s ? IDLE : WAIT_IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= 2'b11;
      cnt         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sync        <= {sync[0], rx_serial};
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      cnt         <= nxt != state || full ? '0 : sample_tick ? cnt + 1'b1 : cnt;
      if (state == START) bit_cnt <= '0;
      if (state == DATA && full) begin
        sh      <= {rx_s, sh[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && full) begin
        if (rx_s) begin
          rx_data  <= sh;
          rx_valid <= !perr;
        end else frame_error <= 1'b1;
      end
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par_odd;
  always_ff @(posedge clk)
    if (reset) begin
      par_odd      <= 1'b0;
      perr         <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= state == STOP && full && rx_s && perr;
      if (state == IDLE) par_odd <= parity_odd;
      if (state == PARITY && full) perr <= ^{sh, rx_s, par_odd};
    end
`else
  assign perr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames against a queue-based receive model.
module tb_uart_rx_frame;
  logic clk = 0, reset = 1, sample_tick = 0, rx_serial = 1;
  logic [7:0] rx_data;
  logic rx_valid, frame_error, busy, pe;
  logic parity_odd_v = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1;
`else
  localparam bit PAR = 0;
  assign pe = 1'b0;
`endif
  uart_rx_frame dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .rx_serial(rx_serial),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd_v),
    .parity_error(pe),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_error(frame_error),
    .busy(busy)
  );
  typedef struct packed {logic [2:0] flags; logic [7:0] data;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, nv = 0, nfe = 0, npe = 0, tc = 0;
  logic [7:0] exp_data = 0;
  logic [2:0] prev = 0;
  logic rst_q = 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    tc++;
    sample_tick = (tc % 4 == 0);
  end
  always @(posedge clk) rst_q <= reset;
  // flags are {rx_valid, frame_error, parity_error}; each frame yields exactly one
  always @(negedge clk) begin : compare
    logic [2:0] cur, want;
    cur = {rx_valid, frame_error, pe};
    if (rst_q) begin
      exp_data = 0;
      q.delete();
      prev = 0;
    end else begin
      if (cur != 0) begin
        want = q.size() > 0 ? q[0].flags : 3'b000;
        chk("pulse_kind", cur, want);
        chk("pulse_width", prev & cur, 0);
        if (q.size() > 0) begin
          if (!q[0].flags[1]) exp_data = q[0].data;
          q.pop_front();
        end
        nv += rx_valid;
        nfe += frame_error;
        npe += pe;
      end
      chk("rx_data", rx_data, exp_data);
      prev = cur;
    end
  end
  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (64) @(negedge clk);
  endtask
  task automatic idle(input int n);
    rx_serial = 1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks, input logic bad_par);
    logic p;
    exp_t e;
    p = ^d ^ parity_odd_v ^ bad_par;
    e.data = d;
    e.flags = !stop ? 3'b010 : (PAR && (^d ^ p ^ parity_odd_v)) ? 3'b001 : 3'b100;
    q.push_back(e);
    send_bit(0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit(p);
    rx_serial = stop;
    repeat (stop_clks) @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {rx_valid, frame_error, pe}, 0);
    reset = 0;
    idle(20);
    send_frame(8'hA5, 1, 64, 0);
    chk("a5_busy", busy, 0);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_nv", nv, 1);
    chk("a5_nfe", nfe, 0);
    chk("a5_pending", q.size(), 0);
    idle(40);
    send_frame(8'h00, 1, 64, 0);
    send_frame(8'hFF, 1, 64, 0);
    chk("b2b_data", rx_data, 8'hFF);
    chk("b2b_nv", nv, 3);
    chk("b2b_pending", q.size(), 0);
    idle(40);
    rx_serial = 0;
    repeat (16) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    rx_serial = 1;
    repeat (32) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    idle(100);
    chk("glitch_nv", nv, 3);
    chk("glitch_nfe", nfe, 0);
    send_frame(8'h3C, 0, 160, 0);
    chk("fe_busy_hi", busy, 1);
    chk("fe_nfe", nfe, 1);
    chk("fe_data", rx_data, 8'hFF);
    rx_serial = 1;
    repeat (16) @(negedge clk);
    chk("fe_busy_lo", busy, 0);
    idle(40);
    send_frame(8'h81, 1, 64, 0);
    chk("x81_data", rx_data, 8'h81);
    chk("x81_nv", nv, 4);
    idle(40);
    parity_odd_v = 1;
    send_bit(0);
    repeat (4) send_bit(0);
    rx_serial = 1;
    repeat (32) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {rx_valid, frame_error, pe}, 0);
    idle(400);
    chk("rst_nv", nv, 4);
    chk("rst_nfe", nfe, 1);
    parity_odd_v = 0;
    idle(20);
    send_frame(8'h5A, 1, 64, 0);
    chk("x5a_data", rx_data, 8'h5A);
    chk("x5a_nv", nv, 5);
    if (PAR) begin
      idle(40);
      send_frame(8'h07, 1, 64, 0);
      chk("par_ok_data", rx_data, 8'h07);
      chk("par_ok_nv", nv, 6);
      idle(40);
      send_frame(8'h07, 1, 64, 1);
      chk("par_bad_npe", npe, 1);
      chk("par_bad_nv", nv, 6);
      chk("par_bad_data", rx_data, 8'h07);
    end
    idle(20);
    chk("final_pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer; the receive-side counterpart of the TX frame path.
- Samples the asynchronous serial line on an oversampling tick. Detects the start bit and validates it at its midpoint. Shifts in data bits LSB-first and checks the stop bit.
- Presents each received byte with a one-cycle valid pulse. Sits between the RX pin and the receive-data consumer (FIFO/register interface), sharing the baud generator with TX.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=4).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- sample_tick  input  1  one-clk pulse, OVERSAMPLE times per bit period.
- rx_serial  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last good received word, LSB = first bit on line.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- frame_error  output  1  one-clk pulse when the stop bit samples low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous only; reset is sampled on the clk edge and has priority over everything else. Reset values:
  - rx_data = 0
  - rx_valid = 0
  - frame_error = 0
  - busy = 0
  - state = IDLE
  - tick counter = 0
  - bit counter = 0
  - synchroniser flops = 1
- Synchroniser: rx_serial passes through 2 flops; all decisions use the second flop (rx_s). Line-to-rx_s latency is 2 clk.
- Tick counter: counts sample_tick pulses only. Width is ceil(log2(OVERSAMPLE)). It is cleared on every state change.
- IDLE:
  - On sample_tick with rx_s==0 -> START, counter cleared.
  - No action on non-tick cycles.
- START:
  - On the tick where counter reaches OVERSAMPLE/2-1 (bit midpoint), sample rx_s.
  - rx_s==0 -> DATA, bit counter = 0.
  - rx_s==1 -> IDLE; treated as a glitch, with no output pulse.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into the shift register (shift right, new bit into MSB) and increment the bit counter.
  - After DATA_BITS samples -> STOP. With the macro enabled, go to PARITY instead.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - rx_s==1: rx_data <= shift register; rx_valid=1 for exactly one clk; -> IDLE.
  - rx_s==0: frame_error=1 for one clk; rx_data unchanged; -> WAIT_IDLE.
- WAIT_IDLE: stays here until a sample_tick with rx_s==1 (break/stuck-low protection), then -> IDLE.
- Output timing: rx_valid and frame_error are registered and assert in the clk after the sampling tick. They are never high together and never high for more than 1 clk.
- Back-to-back frames: a start bit beginning immediately after a stop bit is detected. IDLE is re-entered at the stop-bit midpoint, so the next falling edge is seen.
- sample_tick absent: all state and counters hold.
- Reset mid-frame: the partial frame is discarded with no pulse. rx_data returns to 0.
- busy is combinational from state (state != IDLE).

Optional Feature:
- Macro name: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA and a parity_odd input (1 = odd, 0 = even; sampled at frame start).
  - Adds a parity_error output, a one-clk pulse.
  - In PARITY, after OVERSAMPLE ticks, sample the parity bit, then -> STOP.
  - If XOR(data, parity bit, parity_odd) is non-zero: parity_error pulses in the same cycle rx_valid would, and rx_data is still updated but rx_valid is suppressed.
  - Frame error takes precedence: when the stop bit is also low, only frame_error pulses.
- Undefined: no PARITY state, no parity_odd/parity_error ports, frame = start + DATA_BITS + stop.

Test Plan:
- Bench setup: defaults (8 data bits, OVERSAMPLE=16), sample_tick every 4 clk.
- Frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> one rx_valid pulse, rx_data=8'hA5, frame_error=0, busy low after stop-bit midpoint.
- Two back-to-back frames 0x00 then 0xFF, with no idle gap -> two rx_valid pulses, rx_data 0x00 then 0xFF.
- Start glitch: line low for 4 ticks then high -> no rx_valid/frame_error; busy returns low at tick 8; state IDLE.
- Frame 0x3C with stop bit 0, line held low 40 ticks then high -> one frame_error pulse; rx_data keeps previous value; busy stays high until the first high sample; next frame 0x81 received correctly.
- Reset asserted for 1 clk during data bit 4 of a frame -> all outputs 0 next clk; no pulses from the remaining bits; the following clean frame 0x5A is received.
- With UART_RX_PARITY_EN, parity_odd=0:
  - 0x07 with parity bit 1 -> rx_valid, rx_data=0x07.
  - Same frame with parity bit 0 -> parity_error pulse, no rx_valid.
